// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: CPU stores feed a TX FIFO, a small FSM
// serialises each byte, and a status register reports FIFO state and overflow.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0100,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  mem_we,
  input  logic [31:0] mem_write_addr,
  input  logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_addr,
  output logic [31:0] rd_data,
  output logic        rd_hit,
  output logic        tx,
  output logic        irq
);

  localparam int          PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int          CNT_W       = PTR_W + 1;
  localparam int          BAUD_W      = $clog2(CLKS_PER_BIT);
  localparam logic [31:0] STATUS_ADDR = BASE_ADDR + 32'd4;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state, state_nxt;
  logic [7:0]         fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               overflow;
  logic [BAUD_W-1:0]  baud_cnt;
  logic [2:0]         bit_cnt;
  logic [7:0]         shreg;
  logic               tx_d;
  logic               pop;

  logic               fifo_empty, fifo_full, bit_done;
  logic               push_req, push_ok, clr_req;
  logic               rd_is_data, rd_is_status;
  logic [31:0]        status_word;
  logic               unused_bits;

  assign fifo_empty   = (count == '0);
  assign fifo_full    = (count == CNT_W'(FIFO_DEPTH));
  assign bit_done     = (baud_cnt == BAUD_W'(CLKS_PER_BIT - 1));
  assign push_req     = mem_we[0] && (mem_write_addr == BASE_ADDR);
  assign clr_req      = mem_we[0] && (mem_write_addr == STATUS_ADDR) && mem_write_data[3];
  // A full FIFO still takes a byte when the transmitter frees a slot in the same cycle.
  assign push_ok      = push_req && (!fifo_full || pop);
  assign rd_is_data   = (mem_read_addr == BASE_ADDR);
  assign rd_is_status = (mem_read_addr == STATUS_ADDR);
  assign status_word  = {15'd0, 9'(count), 4'd0, overflow, (state != IDLE), fifo_empty, fifo_full};
  assign irq          = fifo_empty && (state == IDLE);
  assign unused_bits  = ^{mem_we[3:1], mem_write_data[31:8]};

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!fifo_empty) state_nxt = START;
      START:   if (bit_done) state_nxt = DATA;
      DATA:    if (bit_done && (bit_cnt == 3'd7)) state_nxt = STOP;
      STOP:    if (bit_done) state_nxt = fifo_empty ? IDLE : START;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs (line level before the tx flop, FIFO pop strobe)
  always_comb begin
    tx_d = 1'b1;
    pop  = 1'b0;
    case (state)
      IDLE:    pop  = !fifo_empty;
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg[0];
      STOP:    pop  = bit_done && !fifo_empty;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx       <= 1'b1;
      baud_cnt <= '0;
      bit_cnt  <= '0;
    end else begin
      tx <= tx_d;
      if ((state == IDLE) || bit_done) baud_cnt <= '0;
      else                             baud_cnt <= baud_cnt + 1'b1;
      if (state != DATA)  bit_cnt <= '0;
      else if (bit_done)  bit_cnt <= bit_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push_req && !push_ok) overflow <= 1'b1;
      else if (clr_req)         overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) fifo_mem[wr_ptr] <= mem_write_data[7:0];
    if (pop)                          shreg <= fifo_mem[rd_ptr];
    else if ((state == DATA) && bit_done) shreg <= {1'b0, shreg[7:1]};
  end

  // Load response stage: one cycle after the address
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_hit  <= 1'b0;
      rd_data <= '0;
    end else begin
      rd_hit  <= rd_is_data || rd_is_status;
      rd_data <= rd_is_status ? status_word : 32'd0;
    end
  end

endmodule

// File: doc/mmio_uart_tx.md
MMIO_UART_TX -- requirements
Module: mmio_uart_tx

Interface
REQ-001 Parameter BASE_ADDR, default 32'hFFFF_0100, byte address of the TX data register; status register at BASE_ADDR+4.
REQ-002 Parameter CLKS_PER_BIT, default 868, clk cycles per UART bit; legal range 2..65535.
REQ-003 Parameter FIFO_DEPTH, default 16, TX FIFO entries; power of two, 2..256.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 mem_we  input  4  per-byte write enables of the CPU store port.
REQ-007 mem_write_addr  input  32  CPU store address.
REQ-008 mem_write_data  input  32  CPU store data.
REQ-009 mem_read_addr  input  32  CPU load address.
REQ-010 rd_data  output  32  registered load data for the addressed register.
REQ-011 rd_hit  output  1  registered flag; the load one cycle earlier addressed this block.
REQ-012 tx  output  1  UART serial line, 8N1, idle high.
REQ-013 irq  output  1  high while the FIFO is empty and the FSM is IDLE.

Function
REQ-014 Push: a cycle with mem_write_addr==BASE_ADDR and mem_we[0]==1 is a push of mem_write_data[7:0]; mem_we[3:1] ignored.
REQ-015 A push is accepted when count<FIFO_DEPTH, or count==FIFO_DEPTH with a pop in the same cycle.
REQ-016 A rejected push discards the byte, sets sticky overflow, and leaves FIFO contents and count unchanged.
REQ-017 Simultaneous accepted push and pop leaves count unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-018 A write with mem_write_addr==BASE_ADDR+4, mem_we[0]==1 and mem_write_data[3]==1 clears overflow; a same-cycle rejected push wins (overflow stays 1).
REQ-019 Writes to any other address, or with mem_we[0]==0, have no effect.
REQ-020 Status word: bit0 full (count==FIFO_DEPTH), bit1 empty (count==0), bit2 busy (FSM not IDLE), bit3 overflow, bits[16:8] count, all other bits 0.
REQ-021 Loads: rd_data and rd_hit register one cycle after mem_read_addr is presented; BASE_ADDR returns 0 (data register write-only); BASE_ADDR+4 returns the status sampled in the address cycle; any other address returns rd_hit=0, rd_data=0.
REQ-022 FSM states IDLE, START, DATA, STOP; a bit counter holds each line value for exactly CLKS_PER_BIT cycles.
REQ-023 IDLE: tx=1; when the FIFO is non-empty, pop the head into the shift register and enter START on the next cycle.
REQ-024 START: tx=0 for CLKS_PER_BIT cycles, then DATA.
REQ-025 DATA: shift out 8 bits LSB first, CLKS_PER_BIT cycles each, then STOP.
REQ-026 STOP: tx=1 for CLKS_PER_BIT cycles; at the end, pop the next byte and enter START directly if the FIFO is non-empty, else enter IDLE.
REQ-027 Back-to-back frames: no idle gap beyond the single stop bit; frame length exactly 10*CLKS_PER_BIT cycles.
REQ-028 tx is driven from a flop; no combinational path from any input to tx.
REQ-029 A push to an empty FIFO while IDLE reaches START with first tx=0 two cycles after the push edge.

Reset
REQ-030 rst_n low asynchronously forces: FIFO empty, pointers 0, count 0, overflow 0, FSM IDLE, bit and baud counters 0, tx=1, rd_data=0, rd_hit=0, irq=1.
REQ-031 Reset mid-frame aborts the frame; tx returns to 1 immediately and the FIFO contents are lost.
REQ-032 Pushes and loads during reset are ignored; operation resumes on the first posedge after rst_n rises.

Verification (bench uses CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-033 Push 8'hA5 while IDLE -> tx pattern 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; irq returns to 1 after stop.
REQ-034 Push 8'h01, 8'h02, 8'h03 on consecutive cycles -> three contiguous 40-cycle frames, no idle gap, bytes in order.
REQ-035 Push 6 bytes while the first frame is in START -> 5 accepted (1 in shift register plus 4 in FIFO), sixth dropped; status reads full=1, overflow=1; writing 32'h8 to BASE_ADDR+4 -> overflow=0.
REQ-036 Load BASE_ADDR+4 after reset -> next cycle rd_hit=1, rd_data=32'h0000_0002; load 32'h0000_1000 -> rd_hit=0, rd_data=0.
REQ-037 Deassert rst_n during the DATA state of a frame for 8'hFF -> tx=1 in the same cycle, count=0; after release, push 8'h00 -> one clean frame.
REQ-038 With full FIFO, push in the same cycle STOP ends and pops -> push accepted, count stays 4, overflow stays 0.
